// File: rtl/psg_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// psg_write_arbiter_if
//   Groups the two requester write channels and the PSG-facing bus outputs of
//   psg_write_arbiter into one bundle.
//
//   Requester channels (N = 0 host/config, N = 1 playback/envelope engine):
//     rN_valid  1  write request
//     rN_ready  1  accept (grant) from the arbiter
//     rN_addr   4  PSG register index
//     rN_data   8  PSG register value
//   PSG side:
//     bus_data    8  byte driven onto PSG ui_in
//     bus_phase   1  mirror of the PSG latch (1 = address cycle, 0 = data cycle)
//     busy        1  a transaction is in its address or data cycle
//     wr_done     1  pulse in the data cycle of every sequenced write
//     wr_done_id  1  requester id of the write flagged by wr_done
//     wr_skipped  1  pulse after a write was absorbed by the shadow filter
//
//   Modports: slave = the arbiter, master = the requesters / PSG observer.
// -----------------------------------------------------------------------------
interface psg_write_arbiter_if;
   logic       r0_valid;
   logic       r0_ready;
   logic [3:0] r0_addr;
   logic [7:0] r0_data;
   logic       r1_valid;
   logic       r1_ready;
   logic [3:0] r1_addr;
   logic [7:0] r1_data;
   logic [7:0] bus_data;
   logic       bus_phase;
   logic       busy;
   logic       wr_done;
   logic       wr_done_id;
   logic       wr_skipped;

   modport slave (
      input  r0_valid, r0_addr, r0_data,
      input  r1_valid, r1_addr, r1_data,
      output r0_ready, r1_ready,
      output bus_data, bus_phase, busy, wr_done, wr_done_id, wr_skipped
   );

   modport master (
      output r0_valid, r0_addr, r0_data,
      output r1_valid, r1_addr, r1_data,
      input  r0_ready, r1_ready,
      input  bus_data, bus_phase, busy, wr_done, wr_done_id, wr_skipped
   );
endinterface

// File: rtl/psg_write_arbiter.sv
// -----------------------------------------------------------------------------
// psg_write_arbiter
//   Two-requester write arbiter and bus sequencer for the AY-3-8913 PSG
//   register file. Each accepted {addr, data} request is turned into one
//   address cycle followed by one data cycle on the PSG ui_in byte. The PSG
//   latch toggles every cycle from reset, so bus_phase free-runs in lockstep
//   with it and grants are only issued in data-phase cycles.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset, released together with the PSG
//     psg    psg_write_arbiter_if.slave (requester channels + PSG bus outputs)
//
//   Parameters:
//     ARB_MODE   0 = fixed priority (requester 0 wins), 1 = round-robin
//     IDLE_ADDR  register index shown in idle address cycles (14 or 15)
//
//   Optional feature (macro PSG_WRITE_FILTER_EN):
//     Shadow copy of registers 0..13. A granted write that would store the
//     value already held is acknowledged but not sequenced; wr_skipped pulses
//     the cycle after. Without the macro wr_skipped is tied low.
// -----------------------------------------------------------------------------
module psg_write_arbiter #(
   parameter int         ARB_MODE  = 1,
   parameter logic [3:0] IDLE_ADDR = 4'd15
) (
   input logic                 clk,
   input logic                 rst_n,
   psg_write_arbiter_if.slave  psg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       phase_q;       // 1 = PSG address cycle, 0 = data cycle
   logic [3:0] held_addr_q;
   logic [7:0] held_data_q;
   logic       held_id_q;
   logic       rr_ptr_q;      // requester favoured on the next tie
   logic       skipped_q;

   logic       grant;
   logic       win_id;
   logic [3:0] win_addr;
   logic [7:0] win_data;
   logic       filtered;

   // ---------------------------------------------------------------------------
   // Arbitration: a slot exists in every data-phase cycle that is not an
   // address cycle (IDLE or DATA). A lone requester always wins.
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default first so no
   // path leaves it unassigned; otherwise a latch is inferred.
   always_comb begin
      win_id = 1'b0;
      if (psg.r0_valid && psg.r1_valid)
         win_id = (ARB_MODE != 0) ? rr_ptr_q : 1'b0;
      else if (psg.r1_valid)
         win_id = 1'b1;
      grant    = !phase_q && (state_q != ADDR) && (psg.r0_valid || psg.r1_valid);
      win_addr = win_id ? psg.r1_addr : psg.r0_addr;
      win_data = win_id ? psg.r1_data : psg.r0_data;
   end

`ifdef PSG_WRITE_FILTER_EN
   logic [7:0]  shadow_q [14];
   logic [13:0] shadow_valid_q;

   // Writes to 14/15 are never filtered; the index guard comes first so the
   // shadow lookup is never evaluated out of range.
   always_comb begin
      filtered = 1'b0;
      if (grant && (win_addr < 4'd14))
         filtered = shadow_valid_q[win_addr] && (shadow_q[win_addr] == win_data);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         shadow_valid_q <= '0;
      else if (grant && !filtered && (win_addr < 4'd14))
         shadow_valid_q[win_addr] <= 1'b1;
   end

   // NOTE: the shadow contents need no reset; the valid bits, which are reset,
   // gate every read, and leaving the array unreset lets it map to plain RAM.
   always_ff @(posedge clk) begin
      if (grant && !filtered && (win_addr < 4'd14))
         shadow_q[win_addr] <= win_data;
   end
`else
   assign filtered = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = (grant && !filtered) ? ADDR : IDLE;
         ADDR:    state_d = DATA;
         DATA:    state_d = (grant && !filtered) ? ADDR : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         phase_q     <= 1'b0;
         held_addr_q <= 4'h0;
         held_data_q <= 8'h00;
         held_id_q   <= 1'b0;
         rr_ptr_q    <= 1'b0;
         skipped_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= !phase_q;
         skipped_q <= filtered;
         if (grant)
            rr_ptr_q <= !win_id;
         if (grant && !filtered) begin
            held_addr_q <= win_addr;
            held_data_q <= win_data;
            held_id_q   <= win_id;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: bus_data decodes registered state only, never the live payload.
   // ---------------------------------------------------------------------------
   always_comb begin
      unique case (state_q)
         ADDR:    psg.bus_data = {4'h0, held_addr_q};
         DATA:    psg.bus_data = held_data_q;
         default: psg.bus_data = phase_q ? {4'h0, IDLE_ADDR} : 8'h00;
      endcase
   end

   assign psg.r0_ready   = grant && !win_id;
   assign psg.r1_ready   = grant && win_id;
   assign psg.bus_phase  = phase_q;
   assign psg.busy       = (state_q != IDLE);
   assign psg.wr_done    = (state_q == DATA);
   assign psg.wr_done_id = held_id_q;
   assign psg.wr_skipped = skipped_q;

endmodule

// File: tb/tb_psg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_psg_write_arbiter
//   Drives a fixed-priority and a round-robin instance with identical request
//   streams and compares every output, every cycle, against a cycle-indexed
//   reference model: a write granted in cycle g shows its address in g+1 and
//   its data (with wr_done) in g+2; otherwise the bus idles.
// -----------------------------------------------------------------------------
module tb_psg_write_arbiter;

   localparam logic [3:0] IDLE_ADDR = 4'd15;

   typedef struct packed {
      logic       r0_ready;
      logic       r1_ready;
      logic [7:0] bus_data;
      logic       bus_phase;
      logic       busy;
      logic       wr_done;
      logic       wr_done_id;
      logic       wr_skipped;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   psg_write_arbiter_if if_fp ();
   psg_write_arbiter_if if_rr ();

   psg_write_arbiter #(.ARB_MODE(0), .IDLE_ADDR(IDLE_ADDR)) dut_fp (
      .clk   (clk),
      .rst_n (rst_n),
      .psg   (if_fp)
   );

   psg_write_arbiter #(.ARB_MODE(1), .IDLE_ADDR(IDLE_ADDR)) dut_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .psg   (if_rr)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;          // cycles since reset release
   string nm [2]  = '{"fp", "rr"};

   // Reference model state, index 0 = fixed priority, 1 = round-robin.
   bit         fav    [2];      // requester favoured on a tie (round-robin only)
   bit         g_val  [2];
   int         g_cyc  [2];      // cycle of the most recent sequenced grant
   logic [3:0] g_addr [2];
   logic [7:0] g_data [2];
   bit         g_id   [2];
   int         skip_at[2];
   bit         sh_v   [2][14];
   logic [7:0] sh_d   [2][14];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      cyc = 0;
      for (int m = 0; m < 2; m++) begin
         fav[m]     = 1'b0;
         g_val[m]   = 1'b0;
         g_cyc[m]   = 0;
         skip_at[m] = -1;
         for (int r = 0; r < 14; r++) sh_v[m][r] = 1'b0;
      end
   endtask

   function automatic obs_t sample(input int m);
      obs_t o;
      if (m == 0)
         o = '{if_fp.r0_ready, if_fp.r1_ready, if_fp.bus_data, if_fp.bus_phase,
               if_fp.busy, if_fp.wr_done, if_fp.wr_done_id, if_fp.wr_skipped};
      else
         o = '{if_rr.r0_ready, if_rr.r1_ready, if_rr.bus_data, if_rr.bus_phase,
               if_rr.busy, if_rr.wr_done, if_rr.wr_done_id, if_rr.wr_skipped};
      return o;
   endfunction

   // Checks one instance for the current cycle, then applies the clock edge.
   task automatic model_cycle(input int m, input obs_t o,
                              input bit v0, input logic [3:0] a0, input logic [7:0] d0,
                              input bit v1, input logic [3:0] a1, input logic [7:0] d1);
      bit         ph   = cyc[0];
      logic [7:0] ebus = ph ? {4'h0, IDLE_ADDR} : 8'h00;
      bit         ebusy = 1'b0;
      bit         edone = 1'b0;
      bit         any, w, hit;
      logic [3:0] wa;
      logic [7:0] wd;
      if (g_val[m] && cyc == g_cyc[m] + 1) begin
         ebus = {4'h0, g_addr[m]}; ebusy = 1'b1;
      end else if (g_val[m] && cyc == g_cyc[m] + 2) begin
         ebus = g_data[m]; ebusy = 1'b1; edone = 1'b1;
      end
      any = !ph && (v0 || v1);
      w   = (v0 && v1) ? ((m == 1) ? fav[m] : 1'b0) : v1;
      check({nm[m], "_r0_ready"}, 32'(o.r0_ready), 32'(any && !w));
      check({nm[m], "_r1_ready"}, 32'(o.r1_ready), 32'(any && w));
      check({nm[m], "_bus_data"}, 32'(o.bus_data), 32'(ebus));
      check({nm[m], "_bus_phase"}, 32'(o.bus_phase), 32'(ph));
      check({nm[m], "_busy"}, 32'(o.busy), 32'(ebusy));
      check({nm[m], "_wr_done"}, 32'(o.wr_done), 32'(edone));
      check({nm[m], "_wr_skipped"}, 32'(o.wr_skipped), 32'(skip_at[m] == cyc));
      if (edone) check({nm[m], "_wr_done_id"}, 32'(o.wr_done_id), 32'(g_id[m]));
      if (any) begin
         wa = w ? a1 : a0;
         wd = w ? d1 : d0;
         fav[m] = !w;
         hit = 1'b0;
`ifdef PSG_WRITE_FILTER_EN
         if (wa < 4'd14) hit = sh_v[m][wa] && (sh_d[m][wa] == wd);
`endif
         if (hit) begin
            skip_at[m] = cyc + 1;
         end else begin
            g_val[m] = 1'b1; g_cyc[m] = cyc; g_addr[m] = wa; g_data[m] = wd; g_id[m] = w;
            if (wa < 4'd14) begin
               sh_v[m][wa] = 1'b1; sh_d[m][wa] = wd;
            end
         end
      end
   endtask

   task automatic drive(input bit v0, input logic [3:0] a0, input logic [7:0] d0,
                        input bit v1, input logic [3:0] a1, input logic [7:0] d1);
      if_fp.r0_valid = v0; if_fp.r0_addr = a0; if_fp.r0_data = d0;
      if_fp.r1_valid = v1; if_fp.r1_addr = a1; if_fp.r1_data = d1;
      if_rr.r0_valid = v0; if_rr.r0_addr = a0; if_rr.r0_data = d0;
      if_rr.r1_valid = v1; if_rr.r1_addr = a1; if_rr.r1_data = d1;
   endtask

   // Called 1 time unit after a rising edge; returns at the same point of the
   // next cycle.
   task automatic step(input bit v0, input logic [3:0] a0, input logic [7:0] d0,
                       input bit v1, input logic [3:0] a1, input logic [7:0] d1);
      drive(v0, a0, d0, v1, a1, d1);
      @(negedge clk);
      model_cycle(0, sample(0), v0, a0, d0, v1, a1, d1);
      model_cycle(1, sample(1), v0, a0, d0, v1, a1, d1);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
   endtask

   task automatic align_even();
      if (cyc[0]) idle(1);
   endtask

   task automatic reset_outputs_check(input string tag);
      check({tag, "_fp_bus_data"}, 32'(if_fp.bus_data), 32'h00);
      check({tag, "_fp_phase"}, 32'(if_fp.bus_phase), 32'h0);
      check({tag, "_fp_busy"}, 32'(if_fp.busy), 32'h0);
      check({tag, "_fp_wr_done"}, 32'(if_fp.wr_done), 32'h0);
      check({tag, "_rr_bus_data"}, 32'(if_rr.bus_data), 32'h00);
      check({tag, "_rr_phase"}, 32'(if_rr.bus_phase), 32'h0);
      check({tag, "_rr_busy"}, 32'(if_rr.busy), 32'h0);
      check({tag, "_rr_wr_done"}, 32'(if_rr.wr_done), 32'h0);
      check({tag, "_rr_wr_done_id"}, 32'(if_rr.wr_done_id), 32'h0);
      check({tag, "_rr_wr_skipped"}, 32'(if_rr.wr_skipped), 32'h0);
   endtask

   initial begin
      drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_outputs_check("reset");

      // Single write held from reset release.
      drive(1'b1, 4'd8, 8'h1F, 1'b0, 4'h0, 8'h00);
      rst_n = 1'b1;
      step(1'b1, 4'd8, 8'h1F, 1'b0, 4'h0, 8'h00);
      check("single_addr_byte", 32'(if_rr.bus_data), 32'h08);
      check("single_addr_phase", 32'(if_rr.bus_phase), 32'h1);
      idle(1);
      check("single_data_byte", 32'(if_rr.bus_data), 32'h1F);
      check("single_wr_done", 32'(if_rr.wr_done), 32'h1);
      idle(1);

      // Phase gating: r1 raises valid in an address-phase cycle.
      align_even();
      idle(1);
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'd3, 8'hA5);
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'd3, 8'hA5);
      idle(2);

      // Contention: both requesters continuously valid, distinct payloads.
      align_even();
      for (int i = 0; i < 8; i++)
         step(1'b1, 4'd1, 8'(8'h10 + i), 1'b1, 4'd2, 8'(8'h80 + i));
      for (int i = 0; i < 4; i++)
         step(1'b0, 4'h0, 8'h00, 1'b1, 4'd2, 8'(8'hC0 + i));
      idle(2);

      // Reset asserted during the address cycle of a write.
      align_even();
      step(1'b1, 4'd3, 8'hAA, 1'b0, 4'h0, 8'h00);
      check("midop_busy_before", 32'(if_rr.busy), 32'h1);
      drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
      rst_n = 1'b0;
      #1;
      reset_outputs_check("midop");
      repeat (2) @(posedge clk);
      #1;
      reset_outputs_check("midop_hold");
      rst_n = 1'b1;
      model_reset();
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'd5, 8'h55);
      idle(1);
      check("post_reset_data", 32'(if_rr.bus_data), 32'h55);
      check("post_reset_id", 32'(if_rr.wr_done_id), 32'h1);
      idle(1);

      // Repeated value to R7, then a new value.
      for (int k = 0; k < 3; k++) begin
         align_even();
         step(1'b1, 4'd7, (k == 2) ? 8'h39 : 8'h38, 1'b0, 4'h0, 8'h00);
         idle(2);
      end

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit         v0 = ($urandom_range(0, 9) < 6);
         bit         v1 = ($urandom_range(0, 9) < 6);
         logic [3:0] a0 = 4'($urandom_range(0, 15));
         logic [3:0] a1 = 4'($urandom_range(0, 15));
         logic [7:0] d0 = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         logic [7:0] d1 = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         step(v0, a0, d0, v1, a1, d1);
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/psg_write_arbiter.md
Name: psg_write_arbiter

Overview:
Two-requester write arbiter and bus sequencer for the AY-3-8913 PSG register file.
- Converts {addr, data} write requests into the PSG's alternating address/data byte protocol on ui_in; the PSG's internal latch toggles every cycle.
- Requester 0 is the host/config port; requester 1 is the playback/envelope engine.
- Sits between both masters and the PSG core; keeps its phase mirror in lockstep with the PSG latch.

Parameters:
- ARB_MODE, 1, arbitration policy: 0 = fixed priority (r0 wins), 1 = round-robin.
- IDLE_ADDR, 15, register index driven during idle address cycles; must be an unimplemented register (14 or 15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset; released in the same cycle as the PSG reset
- r0_valid  input  1  requester 0 write request
- r0_ready  output  1  requester 0 accept
- r0_addr  input  4  requester 0 register index
- r0_data  input  8  requester 0 register value
- r1_valid / r1_ready / r1_addr / r1_data  in/out/in/in  1/1/4/8  same meanings for requester 1
- bus_data  output  8  byte to PSG ui_in
- bus_phase  output  1  mirror of PSG latch: 1 = address cycle, 0 = data cycle
- busy  output  1  transaction in ADDR or DATA
- wr_done  output  1  one-cycle pulse in the DATA cycle of each transaction
- wr_done_id  output  1  requester id of the transaction flagged by wr_done
- wr_skipped  output  1  one-cycle pulse when a write is filtered (see Optional Feature)

Behaviour:
- Reset values: bus_phase=0, state=IDLE, bus_data=8'h00, busy=0, wr_done=0, wr_done_id=0, wr_skipped=0, rr pointer=0 (r0 favoured first).
- bus_phase toggles every cycle after reset regardless of activity, matching PSG latch (latch=0 first cycle).
- The first post-reset cycle is a PSG data cycle with bus_data=0. This writes 0 into the reset-latched register 0 by design.
- bus_data is a function of registered state only; there is no combinational path from r*_addr or r*_data.
- States: IDLE, ADDR, DATA.
  - IDLE: bus_data = {4'b0, IDLE_ADDR} when bus_phase=1, 8'h00 when bus_phase=0.
  - ADDR: bus_data = {4'b0, held_addr}, bus_phase=1.
  - DATA: bus_data = held_data, bus_phase=0.
- Grants happen only in cycles with bus_phase=0, in state IDLE or DATA.
  - A grant sets rN_ready=1 for exactly the winner.
  - The payload is captured at that clock edge; next state is ADDR.
- Transitions:
  - IDLE(phase 1) -> IDLE.
  - IDLE(phase 0): grant -> ADDR, else IDLE.
  - ADDR -> DATA always.
  - DATA: grant -> ADDR (back-to-back), else IDLE.
- Latency: accept at edge E. Address is on the bus in cycle E+1. Data is on the bus in cycle E+2. The PSG register is updated at the end of E+2.
- Throughput: one write per 2 cycles sustained.
- rN_ready is combinational from phase, state and both valids. It is never asserted in a phase-1 cycle.
- Requesters hold valid and payload stable until ready. Deasserting valid before ready is legal and abandons the request.
- Fixed priority (ARB_MODE=0): r0 wins any simultaneous request.
- Round-robin (ARB_MODE=1): simultaneous requests go to the non-last-granted requester. The rr pointer updates only on grant. A lone requester always wins.
- Addresses 14/15 are accepted and sequenced normally; the PSG ignores them.
- wr_done asserts in the DATA cycle; wr_done_id = id of that transaction; busy=1 in ADDR/DATA.
- Reset mid-transaction: the transaction is discarded, wr_done is not pulsed, and all outputs return to reset values asynchronously.

Optional Feature:
Macro PSG_WRITE_FILTER_EN.

With the macro defined:
- 14 x 8-bit shadow registers plus valid bits for registers 0..13; all valid bits clear on reset.
- A granted write to addr<14 whose data equals a valid shadow entry is still accepted (ready=1), but:
  - it takes no bus slot and the next state is IDLE;
  - wr_skipped pulses in the following cycle;
  - wr_done does not pulse.
- Non-filtered writes to addr<14 update the shadow and set valid at grant.
- Addresses 14/15 are never filtered.

Without the macro: no shadow storage, and wr_skipped is tied 0.

Test Plan:
- Single write: r0 {addr=8, data=8'h1F} held from reset release -> r0_ready in cycle 0 (phase 0); bus_data=8'h08 with phase=1 in cycle 1; 8'h1F with phase=0 in cycle 2; wr_done=1 and wr_done_id=0 in cycle 2.
- Phase gating: r1 raises valid in a phase-1 cycle -> ready waits one cycle, then addr/data appear in the next two cycles.
- Contention, ARB_MODE=1: both valid continuously with distinct payloads -> grants alternate r0,r1,r0,r1; one write per 2 cycles; no idle cycle between transactions.
- Contention, ARB_MODE=0: both valid for 4 transactions -> r0 granted all 4; r1 starves until r0 drops valid.
- Reset mid-op: assert rst_n=0 during the ADDR cycle -> bus_data=0, phase=0, busy=0 immediately; no wr_done; a fresh write after release completes normally.
- Filter (PSG_WRITE_FILTER_EN): write R7=8'h38 twice -> first is sequenced; second gives ready=1, wr_skipped=1, no bus activity (bus shows IDLE_ADDR/00); then R7=8'h39 -> sequenced.
